// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage of the RV32I pipeline.
// This stage owns the PC, drives the instruction-memory address and loads the IF/ID register.
// Redirects from the branch unit flush the wrong-path fetch and are counted in flush_cnt.
// The stage also honours hazard stalls, memory wait states and ebreak halt/resume.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        next_pc_src,
  input  logic [31:0] target_pc,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // What the IF/ID register does this cycle.
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_FETCH  = 2'd2
  } ifid_sel_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc16 = 16'hFFFF;
    end else begin
      sat_inc16 = v + 16'd1;
    end
  endfunction

  // Word-aligned redirect target; the low two bits are never meaningful for RV32I fetch.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    align_word = {a[31:2], 2'b00};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        halted_q, halted_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  ifid_sel_e   ifid_sel_s;
  logic [31:0] pc_plus4_s;

  // Sequential PC, wrapping naturally modulo 2^32.
  assign pc_plus4_s = pc_q + 32'd4;

  // FSM next state, PC update, flush counting and choice of IF/ID action.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    ifid_sel_s  = IFID_HOLD;
    case (state_q)
      ST_BOOT: begin
        // One settling cycle after reset: nothing is fetched.
        state_d    = ST_RUN;
        ifid_sel_s = IFID_BUBBLE;
      end
      ST_RUN: begin
        if (next_pc_src) begin
          // A redirect beats stall, halt and wait states: the fetched word is wrong-path.
          pc_d        = align_word(target_pc);
          ifid_sel_s  = IFID_BUBBLE;
          flush_cnt_d = sat_inc16(flush_cnt_q);
        end else begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
          if (stall) begin
            ifid_sel_s = IFID_HOLD;
          end else if (halt_req || !imem_ready) begin
            // Halting or waiting on memory: keep the PC and feed a bubble downstream.
            ifid_sel_s = IFID_BUBBLE;
          end else begin
            ifid_sel_s = IFID_FETCH;
            pc_d       = pc_plus4_s;
          end
        end
      end
      ST_HALT: begin
        ifid_sel_s = IFID_BUBBLE;
        if (next_pc_src) begin
          state_d     = ST_RUN;
          pc_d        = align_word(target_pc);
          flush_cnt_d = sat_inc16(flush_cnt_q);
        end else if (resume) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean restart sequence.
        state_d    = ST_BOOT;
        ifid_sel_s = IFID_BUBBLE;
      end
    endcase
    if (state_d == ST_HALT) begin
      halted_d = 1'b1;
    end else begin
      halted_d = 1'b0;
    end
  end

  // IF/ID register input mux driven by the action chosen above.
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    case (ifid_sel_s)
      IFID_HOLD: begin
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
      end
      IFID_BUBBLE: begin
        ifid_pc_d    = pc_q;
        ifid_pc4_d   = pc_plus4_s;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      IFID_FETCH: begin
        ifid_pc_d    = pc_q;
        ifid_pc4_d   = pc_plus4_s;
        ifid_instr_d = imem_rdata;
        ifid_valid_d = 1'b1;
      end
      default: begin
        ifid_pc_d    = pc_q;
        ifid_pc4_d   = pc_plus4_s;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  // All stage state; reset asynchronously drops any in-flight instruction and the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      flush_cnt_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = halted_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
